// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the matching transmitter.
//   UART_D_WIDTH  : data bits per frame on the link
//   uart_state_e  : receiver frame-tracking states
package uart_pkg;

    localparam int UART_D_WIDTH = 13;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line.
// Flops reset to 1 (line idle level) so a reset never looks like a start bit.
//   clk : system clock
//   rst : asynchronous active-low reset
//   d   : asynchronous input
//   q   : synchronised output, SYNC_STAGES clocks behind d
module uart_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises idle-high frames (start 0, D_WIDTH data bits
// LSB first, stop 1) and hands each good word over a valid/ack register.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   rx         : serial line, asynchronous, idles high
//   rx_ack     : consumer accepts rx_data while rx_valid=1
//   rx_data    : last good word, bit 0 = first data bit received
//   rx_valid   : rx_data holds an unacknowledged word
//   rx_busy    : frame in progress (START, DATA, STOP)
//   rx_ferr    : one-cycle pulse, stop bit sampled low
//   rx_overrun : one-cycle pulse, good frame dropped because rx_valid was set
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s=0
// START     | counting to mid start bit to reject glitches
// DATA      | sampling D_WIDTH data bits, one per CLKS_PER_BIT clocks
// STOP      | waiting for the stop-bit sample
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int D_WIDTH      = UART_D_WIDTH,
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ack,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_ferr,
    output logic               rx_overrun
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int PW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(D_WIDTH + 1);

    localparam logic [PW-1:0] PHASE_HALF = PW'(HALF);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(D_WIDTH - 1);

    uart_state_e        state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [D_WIDTH-1:0] shift_q;
    logic               rx_s;
    logic               data_sample;
    logic               stop_good;
    logic               stop_bad;
    logic               load;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    // phase_q tracks the clock offset within the current bit; samples are
    // taken when it reaches the last offset, so the first data sample lands
    // one full bit after the mid-start point.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        data_sample = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    bit_d = '0;
                    if (HALF == 0) begin
                        state_d = DATA;
                        phase_d = '0;
                    end else begin
                        state_d = START;
                        phase_d = PW'(1);
                    end
                end
            end
            START: begin
                if (phase_q == PHASE_HALF) begin
                    phase_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            DATA: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d     = '0;
                    data_sample = 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            STOP: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (rx_s) begin
                        stop_good = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A same-cycle ack frees the holding register, so the new word wins.
    assign load = stop_good && (!rx_valid || rx_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_busy    <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (data_sample) begin
                shift_q <= {rx_s, shift_q[D_WIDTH-1:1]};
            end
            if (load) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            rx_busy    <= (state_d == START) || (state_d == DATA) || (state_d == STOP);
            rx_ferr    <= stop_bad;
            rx_overrun <= stop_good && !load;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance at 1 clock/bit, one at 4.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = UART_D_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx1, ack1, rx4, ack4;
    logic [DW-1:0] data1, data4;
    logic          valid1, busy1, ferr1, ovr1;
    logic          valid4, busy4, ferr4, ovr4;

    always #5 clk = ~clk;

    uart_rx dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_ack(ack1),
        .rx_data(data1), .rx_valid(valid1), .rx_busy(busy1),
        .rx_ferr(ferr1), .rx_overrun(ovr1)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .rx_ack(ack4),
        .rx_data(data4), .rx_valid(valid4), .rx_busy(busy4),
        .rx_ferr(ferr4), .rx_overrun(ovr4)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int nferr1 = 0, novr1 = 0, nferr4 = 0, novr4 = 0;
    logic          pv1 = 1'b0;
    int            nw1 = 0;
    logic [DW-1:0] words1 [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and delivery monitors, sampled on the pre-edge values.
    always @(posedge clk) begin
        if (ferr1) nferr1 <= nferr1 + 1;
        if (ovr1)  novr1  <= novr1 + 1;
        if (ferr4) nferr4 <= nferr4 + 1;
        if (ovr4)  novr4  <= novr4 + 1;
        pv1 <= valid1;
        if (valid1 && !pv1 && nw1 < 32) begin
            words1[nw1] <= data1;
            nw1 <= nw1 + 1;
        end
    end

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] exp_data;
        int            exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int inst, input logic b);
        if (inst == 4) rx4 = b;
        else           rx1 = b;
    endtask

    // Called at a negedge; e0 is the edge where the first sync flop sees the start bit.
    task automatic send(input int inst, input logic [DW-1:0] w, input logic stop_bit, output int e0);
        int cpb;
        cpb = (inst == 4) ? 4 : 1;
        e0 = cyc + 1;
        set_rx(inst, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            set_rx(inst, w[i]);
            repeat (cpb) @(negedge clk);
        end
        set_rx(inst, stop_bit);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic wait_valid(input int inst, input int budget, output int rc);
        rc = -1;
        for (int i = 0; i < budget; i++) begin
            if ((inst == 4) ? valid4 : valid1) begin
                rc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int e0, e0a, e0b, rc, fe, ov, base;
        logic [DW-1:0] w;

        vecs[0] = '{13'h1A5B, 13'h1A5B, 16};
        vecs[1] = '{13'h0000, 13'h0000, 16};
        vecs[2] = '{13'h1FFF, 13'h1FFF, 16};
        vecs[3] = '{13'h0001, 13'h0001, 16};
        vecs[4] = '{13'h1000, 13'h1000, 16};
        vecs[5] = '{13'h1555, 13'h1555, 16};

        rst = 1'b0; rx1 = 1'b1; rx4 = 1'b1; ack1 = 1'b0; ack4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid1", valid1, 0);
        check("rst_data1",  data1,  0);
        check("rst_busy1",  busy1,  0);
        check("rst_ferr1",  ferr1,  0);
        check("rst_ovr1",   ovr1,   0);
        check("rst_valid4", valid4, 0);
        check("rst_data4",  data4,  0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single frames at default rate, checked for latency and content.
        for (int i = 0; i < 6; i++) begin
            fe = nferr1; ov = novr1;
            send(1, vecs[i].word, 1'b1, e0);
            wait_valid(1, 40, rc);
            check("vec_latency", rc - e0, vecs[i].exp_lat);
            check("vec_data", data1, vecs[i].exp_data);
            check("vec_busy_done", busy1, 0);
            repeat (2) @(negedge clk);
            check("vec_flags", (nferr1 - fe) + (novr1 - ov), 0);
            ack1 = 1'b1; @(negedge clk); ack1 = 1'b0;
            check("vec_ack_clears", valid1, 0);
            ack1 = 1'b1; @(negedge clk); ack1 = 1'b0;
            check("vec_idle_ack_ignored", valid1, 0);
            check("vec_data_held", data1, vecs[i].exp_data);
        end

        // Back-to-back frames with ack one cycle after each valid.
        base = nw1; fe = nferr1; ov = novr1;
        fork
            begin
                send(1, 13'h0001, 1'b1, e0a);
                send(1, 13'h1FFF, 1'b1, e0b);
            end
            begin
                int rca;
                for (int k = 0; k < 2; k++) begin
                    wait_valid(1, 60, rca);
                    @(negedge clk) ack1 = 1'b1;
                    @(negedge clk) ack1 = 1'b0;
                end
            end
        join
        repeat (3) @(negedge clk);
        check("b2b_count", nw1 - base, 2);
        check("b2b_word0", words1[base], 13'h0001);
        check("b2b_word1", words1[base+1], 13'h1FFF);
        check("b2b_flags", (nferr1 - fe) + (novr1 - ov), 0);
        check("b2b_valid", valid1, 0);

        // Overrun, then a frame whose stop sample coincides with ack.
        send(1, 13'h0AAA, 1'b1, e0);
        wait_valid(1, 40, rc);
        check("ovr_first_data", data1, 13'h0AAA);
        fe = nferr1; ov = novr1;
        send(1, 13'h1234, 1'b1, e0);
        repeat (4) @(negedge clk);
        check("ovr_pulse", novr1 - ov, 1);
        check("ovr_data_kept", data1, 13'h0AAA);
        check("ovr_valid_kept", valid1, 1);
        check("ovr_no_ferr", nferr1 - fe, 0);
        ov = novr1;
        send(1, 13'h0765, 1'b1, e0);
        @(negedge clk) ack1 = 1'b1;
        @(negedge clk) ack1 = 1'b0;
        repeat (2) @(negedge clk);
        check("ackload_data", data1, 13'h0765);
        check("ackload_valid", valid1, 1);
        check("ackload_no_ovr", novr1 - ov, 0);
        ack1 = 1'b1; @(negedge clk); ack1 = 1'b0;
        check("ackload_cleared", valid1, 0);

        // Framing error with the line held low afterwards.
        fe = nferr1; ov = novr1;
        send(1, 13'h1111, 1'b0, e0);
        repeat (20) @(negedge clk);
        check("ferr_pulse", nferr1 - fe, 1);
        check("ferr_valid", valid1, 0);
        check("ferr_busy_low", busy1, 0);
        check("ferr_data_kept", data1, 13'h0765);
        check("ferr_no_ovr", novr1 - ov, 0);
        rx1 = 1'b1;
        repeat (3) @(negedge clk);
        send(1, 13'h0123, 1'b1, e0);
        wait_valid(1, 40, rc);
        check("ferr_next_latency", rc - e0, 16);
        check("ferr_next_data", data1, 13'h0123);

        // Four clocks per bit: reject a one-clock glitch, then a full frame.
        fe = nferr4; ov = novr4;
        rx4 = 1'b0; @(negedge clk); rx4 = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_valid", valid4, 0);
        check("glitch_busy", busy4, 0);
        check("glitch_flags", (nferr4 - fe) + (novr4 - ov), 0);
        send(4, 13'h1555, 1'b1, e0);
        wait_valid(4, 80, rc);
        check("cpb4_latency", rc - e0, 59);
        check("cpb4_data", data4, 13'h1555);
        repeat (2) @(negedge clk);
        check("cpb4_flags", (nferr4 - fe) + (novr4 - ov), 0);

        // Reset in the middle of the data bits (valid1 still holds 0x0123).
        fe = nferr1; ov = novr1;
        w = 13'h1ABC;
        rx1 = 1'b0; @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx1 = w[i]; @(negedge clk);
        end
        check("midrst_busy_before", busy1, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_data1",  data1,  0);
        check("midrst_valid1", valid1, 0);
        check("midrst_busy1",  busy1,  0);
        check("midrst_data4",  data4,  0);
        check("midrst_valid4", valid4, 0);
        rx1 = 1'b1;
        @(negedge clk) rst = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_delivery", valid1, 0);
        check("midrst_no_flags", (nferr1 - fe) + (novr1 - ov), 0);
        send(1, 13'h0F0F, 1'b1, e0);
        wait_valid(1, 40, rc);
        check("midrst_next_latency", rc - e0, 16);
        check("midrst_next_data", data1, 13'h0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive end of the team's single-wire UART link; deserialises frames produced by the matching transmitter.
- Frame format on the line:
  - idle high;
  - one start bit (0);
  - D_WIDTH data bits, LSB first;
  - at least one stop bit (1).
- Samples the line at CLKS_PER_BIT clocks per bit. The default of 1 matches the transmitter's one-bit-per-clock shifting.
- Delivers each word through a valid/ack holding register, and flags framing errors and overruns.

Parameters:
- D_WIDTH, 13: data bits per frame.
- CLKS_PER_BIT, 1: clocks per bit period; must be ≥1.
- SYNC_STAGES, 2: flops in the input synchroniser; must be ≥2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous to clk; idles high.
- rx_ack  in  1  consumer accepts rx_data while rx_valid=1.
- rx_data  out  D_WIDTH  last good word, LSB = first data bit received.
- rx_valid  out  1  rx_data holds an unacknowledged word.
- rx_busy  out  1  high in START, DATA and STOP.
- rx_ferr  out  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  out  1  one-cycle pulse: a good frame was dropped because rx_valid was still set.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counters=0; shift register=0.
  - Synchroniser flops reset to 1, so no false start after reset.
  - rx_data=0, rx_valid=0, rx_busy=0, rx_ferr=0, rx_overrun=0.
- Reset mid-frame aborts the frame. Nothing is delivered and no flags are raised.
- rx_s is the synchronised rx, delayed SYNC_STAGES clocks. HALF=(CLKS_PER_BIT-1)/2, using integer division.
- IDLE:
  - rx_s=0 is the start-detect edge, offset 0.
  - If HALF=0, go to DATA with bit_cnt=0 and phase_cnt=0; otherwise go to START with phase_cnt=1.
- START:
  - phase_cnt increments each clock.
  - At offset HALF, sample rx_s. If 1, this is a glitch: return to IDLE with no flag. If 0, go to DATA with phase_cnt reset.
- DATA:
  - A sample is taken every CLKS_PER_BIT clocks, at offsets HALF+CLKS_PER_BIT*(k+1) for k=0..D_WIDTH-1.
  - Each sample is shifted in MSB-first into the shift register, so the first bit ends in bit 0.
  - After sample k=D_WIDTH-1, go to STOP.
- STOP sample, taken at offset HALF+CLKS_PER_BIT*(D_WIDTH+1):
  - rx_s=1, good frame:
    - If rx_valid=0 or rx_ack=1 that cycle: load rx_data and set rx_valid on this edge.
    - Otherwise: keep the old rx_data and pulse rx_overrun.
    - Go to IDLE. The remaining half stop bit is not waited for, which permits back-to-back frames.
  - rx_s=0: pulse rx_ferr, leave rx_data and rx_valid unchanged, and go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This covers break and line-stuck-low; a new start is never detected while here.
- rx_valid:
  - Set only at a good stop sample.
  - Cleared on a clock with rx_ack=1 and no simultaneous load.
  - rx_ack while rx_valid=0 is ignored.
- Latency for a good frame: rx_valid rises on edge e0+SYNC_STAGES+HALF+CLKS_PER_BIT*(D_WIDTH+1). Here e0 is the edge at which the first synchroniser flop captures the start bit.
  - Defaults: e0+16.
- Counter widths:
  - phase_cnt: $clog2(CLKS_PER_BIT+1) bits; counts offsets within the current bit.
  - bit_cnt: $clog2(D_WIDTH+1) bits.
  - No counter wraps within a legal frame.
- rx_busy is registered; it is high from the edge that leaves IDLE until the edge that takes the stop sample.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, STOP, WAIT_HIGH) and constant UART_D_WIDTH=13, shared with the transmitter.
- Sub-module uart_sync:
  - parameterised SYNC_STAGES flop chain;
  - reset value 1;
  - asynchronous active-low reset.

Test Plan:
1. Defaults; transmitter sends tx_data=13'h1A5B; no ack until seen → rx_valid rises at e0+16, rx_data=13'h1A5B, rx_ferr=0, rx_overrun=0.
2. Back-to-back transmitter frames 13'h0001 then 13'h1FFF, with rx_ack pulsed one cycle after each rx_valid → both words delivered in order; no flags.
3. Second good frame completes while rx_valid is still set from 13'h0AAA with no ack → rx_overrun pulses once; rx_data stays 13'h0AAA; rx_valid stays 1.
4. Stop bit driven 0, then rx held low for 20 clocks → rx_ferr pulses once; rx_valid unchanged; no new frame until rx returns high; a following good frame 13'h0123 is received correctly.
5. CLKS_PER_BIT=4; a 1-clock low glitch on idle rx → state returns to IDLE; no flags; rx_valid stays 0. A subsequent full-rate frame 13'h1555 is received correctly.
6. rst=0 asserted mid-DATA for 1 clock → all outputs 0 immediately (asynchronous); no rx_valid from the aborted frame; the next frame 13'h0F0F is received correctly.
